clk_strobe_gen: RTL and testbench

//  Multi-channel fractional clock-enable generator on the 61.44 MHz audio clock domain.

---
 rtl/clk_strobe_pkg.sv | 26 ++
 rtl/strobe_nco.sv | 67 ++++++
 rtl/clk_strobe_gen.sv | 135 +++++++++++++
 tb/tb_clk_strobe_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_strobe_pkg.sv
// Shared types and helpers for the fractional strobe generator.
package clk_strobe_pkg;

  // Default accumulator / increment width.
  localparam int unsigned DEFAULT_ACC_W = 32;

  // Lock supervisor states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } lock_state_t;

  // Phase increment giving f_out from f_clk with a DEFAULT_ACC_W-bit accumulator
  // (floor of f_out * 2^ACC_W / f_clk); meant for benches and configuration code.
  function automatic logic [63:0] inc_for(input logic [63:0] f_out, input logic [63:0] f_clk);
    logic [63:0] scaled;
    scaled = f_out << DEFAULT_ACC_W;
    if (f_clk == 64'd0) begin
      return 64'd0;
    end else begin
      return scaled / f_clk;
    end
  endfunction

endpackage

// File: rtl/strobe_nco.sv
// One NCO channel: phase accumulator plus a registered one-cycle carry strobe.
// With STROBE_SYNC_EN defined, sync_i reloads the accumulator with the increment.
module strobe_nco
  import clk_strobe_pkg::*;
#(
  parameter int unsigned ACC_W = DEFAULT_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic [ACC_W-1:0] inc_i,
  output logic             strobe_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             strobe_q;
  logic             strobe_d;
  logic [ACC_W:0]   sum_s;

  // Widened sum so the top bit is the wrap carry.
  assign sum_s = {1'b0, acc_q} + {1'b0, inc_i};

`ifndef STROBE_SYNC_EN
  // Realign is not built; sync_i is deliberately left unconnected here.
  logic sync_unused_s;
  assign sync_unused_s = sync_i;
`endif

  // Next phase and strobe: advance while enabled, hold phase and stay quiet otherwise.
  always_comb begin
    acc_d    = acc_q;
    strobe_d = 1'b0;
    if (enable_i) begin
`ifdef STROBE_SYNC_EN
      if (sync_i) begin
        acc_d    = inc_i;
        strobe_d = 1'b0;
      end else begin
        acc_d    = sum_s[ACC_W-1:0];
        strobe_d = sum_s[ACC_W];
      end
`else
      acc_d    = sum_s[ACC_W-1:0];
      strobe_d = sum_s[ACC_W];
`endif
    end else begin
      acc_d    = acc_q;
      strobe_d = 1'b0;
    end
  end

  // Accumulator and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= {ACC_W{1'b0}};
      strobe_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel fractional clock-enable generator: config decode, increment
// registers, NCO channels and the lock supervisor.
// Optional feature macro: STROBE_SYNC_EN (sync_in phase realign of all channels).
module clk_strobe_gen
  import clk_strobe_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned ACC_W       = DEFAULT_ACC_W,
  parameter  int unsigned LOCK_CYCLES = 1024,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic              sync_in,
  output logic [NUM_CH-1:0] strobe,
  output logic              locked
);

  localparam int unsigned      CNT_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic             cfg_ready_q;
  logic             cfg_ready_d;
  logic             wr_s;
  lock_state_t      state_q;
  lock_state_t      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_q;
  logic             locked_d;

  // A write lands when requested and ready; ready then rests for one cycle.
  assign wr_s        = cfg_valid & cfg_ready_q;
  assign cfg_ready_d = ~wr_s;

  // Config handshake ready register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
    end else begin
      cfg_ready_q <= cfg_ready_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_W-1:0] inc_q;

    // Increment register: loads on an accepted write addressed to this channel.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        inc_q <= {ACC_W{1'b0}};
      end else if (wr_s && (cfg_ch == CH_W'(g))) begin
        inc_q <= cfg_inc;
      end else begin
        inc_q <= inc_q;
      end
    end

    strobe_nco #(
      .ACC_W (ACC_W)
    ) u_nco (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable_i (enable),
      .sync_i   (sync_in),
      .inc_i    (inc_q),
      .strobe_o (strobe[g])
    );
  end

  // Lock supervisor: disable beats a write, a write restarts settling, counter saturates.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (enable) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE, LOCKED: begin
        if (!enable) begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (wr_s) begin
          state_d = SETTLE;
          cnt_d   = {CNT_W{1'b0}};
        end else if (state_q == LOCKED) begin
          state_d = LOCKED;
          cnt_d   = cnt_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOCKED;
          cnt_d   = cnt_q;
        end else if (cnt_q != CNT_MAX) begin
          state_d = SETTLE;
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = SETTLE;
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  // Lock state, counter and registered locked flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Randomised bench for clk_strobe_gen with a phase-count reference model.
// NUM_CH=5 so that cfg_ch is 3 bits wide and channel 7 is a real out-of-range target.
module tb_clk_strobe_gen;
  import clk_strobe_pkg::*;

  localparam int unsigned NUM_CH      = 5;
  localparam int unsigned ACC_W       = 32;
  localparam int unsigned LOCK_CYCLES = 1024;
  localparam int unsigned CH_W        = 3;
  localparam longint unsigned TURN    = 64'h1_0000_0000;
`ifdef STROBE_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [ACC_W-1:0]  cfg_inc;
  logic              sync_in;
  logic [NUM_CH-1:0] strobe;
  logic              locked;

  always #5 clk = ~clk;

  clk_strobe_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_inc   (cfg_inc),
    .sync_in   (sync_in),
    .strobe    (strobe),
    .locked    (locked)
  );

  // Reference model: phase as a fraction of a turn, strobe on each completed turn.
  longint unsigned   m_acc [NUM_CH];
  longint unsigned   m_inc [NUM_CH];
  logic [NUM_CH-1:0] m_strobe;
  logic              m_ready;
  logic              m_locked;
  int                m_streak;   // consecutive enabled edges since a write or idle exit
  int                checks = 0;
  int                errors = 0;
  logic [31:0]       hold_inc [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
    end
    m_strobe = '0;
    m_ready  = 1'b0;
    m_locked = 1'b0;
    m_streak = 0;
  endtask

  // Predict outputs after the coming rising edge from the inputs now applied.
  task automatic predict();
    bit wr;
    wr = cfg_valid && m_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!enable) begin
        m_strobe[i] = 1'b0;
      end else if (SYNC_ON && sync_in) begin
        m_acc[i]    = m_inc[i];
        m_strobe[i] = 1'b0;
      end else begin
        m_strobe[i] = ((m_acc[i] + m_inc[i]) >= TURN);
        m_acc[i]    = (m_acc[i] + m_inc[i]) % TURN;
      end
    end
    if (wr && (cfg_ch < NUM_CH)) m_inc[cfg_ch] = cfg_inc;
    m_ready = !wr;
    // Lock needs one idle-exit (or write) edge followed by LOCK_CYCLES clean enabled edges.
    if (!enable) m_streak = 0;
    else if (wr || m_streak == 0) m_streak = 1;
    else if (m_streak <= LOCK_CYCLES) m_streak++;
    m_locked = (m_streak > LOCK_CYCLES);
  endtask

  // One clock: predict, let the edge pass, compare on the falling edge.
  task automatic tick();
    if (rst_n) predict();
    else model_reset();
    @(negedge clk);
    check("strobe", 64'(strobe), 64'(m_strobe));
    check("locked", 64'(locked), 64'(m_locked));
    check("cfg_ready", 64'(cfg_ready), 64'(m_ready));
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      enable    = ($urandom_range(0, 19) != 0);
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_ch    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       cfg_inc = 32'h0000_0000;
        1:       cfg_inc = 32'hFFFF_FFFF;
        2:       cfg_inc = 32'h8000_0000;
        default: cfg_inc = $urandom;
      endcase
      sync_in = ($urandom_range(0, 7) == 0);
      tick();
    end
    cfg_valid = 1'b0;
    sync_in   = 1'b0;
  endtask

  initial begin
    int last, n, cyc, total, iv, first_at, acc_n, cnt;
    logic rdy;
    hold_inc[0] = 32'h4000_0000;
    hold_inc[1] = 32'h1234_5678;
    hold_inc[2] = 32'h2000_0000;
    hold_inc[3] = 32'h0800_0000;

    rst_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; sync_in = 1'b0;
    model_reset();

    // Helper pin: 48 kHz from 61.44 MHz.
    check("inc_for_48k", inc_for(64'd48000, 64'd61440000), 64'h0033_3333);

    // Reset state.
    tick();
    tick();
    check("rst_strobe", 64'(strobe), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_ready", 64'(cfg_ready), 64'd0);

    // Test 1: half-rate channel and first lock.
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(cfg_ready), 64'd1);
    enable = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h8000_0000;
    tick();
    cfg_valid = 1'b0;
    check("ready_drop", 64'(cfg_ready), 64'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("half_rate", 64'(strobe[0]), 64'(k % 2));
    end
    for (int k = 8; k < 1023; k++) tick();
    check("lock_pre", 64'(locked), 64'd0);
    tick();
    check("lock_at_1024", 64'(locked), 64'd1);

    // Test 2: 48 kHz channel spacing.
    cfg_valid = 1'b1; cfg_ch = 3'd1; cfg_inc = 32'h0033_3333;
    tick();
    cfg_valid = 1'b0;
    last = -1; n = 0; cyc = 0; total = 0; first_at = 0;
    while (n < 25 && cyc < 40000) begin
      tick();
      cyc++;
      if (strobe[1]) begin
        if (last >= 0) begin
          iv = cyc - last;
          check("ch1_interval_ok", 64'((iv == 1280) || (iv == 1281)), 64'd1);
          total += iv;
        end else begin
          first_at = cyc;
        end
        last = cyc;
        n++;
      end
    end
    check("ch1_strobe_count", 64'(n), 64'd25);
    check("ch1_first", 64'(first_at), 64'd1281);
    check("ch1_total_24", 64'(total), 64'd30720);

    // Test 3: held cfg_valid over four channels.
    check("locked_before_hold", 64'(locked), 64'd1);
    cfg_valid = 1'b1; acc_n = 0;
    for (int j = 0; j < 4; j++) begin
      cfg_ch  = 3'(j);
      cfg_inc = hold_inc[j];
      rdy = cfg_ready;
      check("hold_ready", 64'(rdy), 64'((j + 1) % 2));
      if (rdy) acc_n++;
      tick();
      if (j == 0) check("lock_drop", 64'(locked), 64'd0);
    end
    cfg_valid = 1'b0;
    check("hold_accepts", 64'(acc_n), 64'd2);

    // Randomised traffic, including sync_in and boundary increments.
    random_cycles(3000);

    // Test 4: enable gap and re-lock.
    enable = 1'b1;
    for (int k = 0; k < 1100; k++) tick();
    check("locked_before_gap", 64'(locked), 64'd1);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("gap_quiet", 64'({strobe, locked}), 64'd0);
    end
    enable = 1'b1; cnt = 0;
    while (!locked && cnt < 2000) begin
      tick();
      cnt++;
    end
    // One idle-exit edge plus LOCK_CYCLES settle edges.
    check("relock_cycles", 64'(cnt), 64'd1025);

    // Test 5: out-of-range channel write, then reset during a strobe.
    cfg_valid = 1'b1; cfg_ch = 3'd7; cfg_inc = 32'hDEAD_BEEF;
    tick();
    cfg_valid = 1'b0;
    check("ch7_ready_drop", 64'(cfg_ready), 64'd0);
    check("ch7_unlock", 64'(locked), 64'd0);
    tick();
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h8000_0000;
    tick();
    cfg_valid = 1'b0;
    cnt = 0;
    while (strobe == '0 && cnt < 10) begin
      tick();
      cnt++;
    end
    check("strobe_seen", 64'(strobe != '0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_strobe", 64'(strobe), 64'd0);
    check("async_rst_locked", 64'(locked), 64'd0);
    check("async_rst_ready", 64'(cfg_ready), 64'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
    random_cycles(500);

`ifdef STROBE_SYNC_EN
    // Test 6: common-phase realign.
    enable = 1'b1;
    cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_inc = 32'h4000_0000;
    while (!cfg_ready) tick();
    tick();
    tick();
    cfg_ch = 3'd1; cfg_inc = 32'h2000_0000;
    tick();
    cfg_valid = 1'b0;
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) check("sync_4", 64'(strobe[1:0]), 64'd1);
      if (k == 7) check("sync_8", 64'(strobe[1:0]), 64'd3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
